// File: rtl/free_tracker_pkg.sv
// free_tracker_pkg: configuration constants for the free tracker slice
package free_tracker_pkg;
    localparam int LOCAL_ADDR_BW0     = 8;
    localparam int N_ICFG             = 2;
    localparam int FREE_TRACKER_DEPTH = 8;
    function automatic int icfg_bw(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/free_tracker_fifo.sv
// free_tracker_fifo: in-order {linear, id} storage with wrapping pointers and occupancy count
module free_tracker_fifo #(
    parameter  int LBW   = 8,
    parameter  int IBW   = 2,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_push,
    input  logic           i_pop,
    input  logic [LBW-1:0] i_linear,
    input  logic [IBW-1:0] i_id,
    output logic [LBW-1:0] o_head_linear,
    output logic [IBW-1:0] o_head_id,
    output logic [CW-1:0]  o_count,
    output logic           o_full
);
    logic [LBW-1:0] r_linear [DEPTH];
    logic [IBW-1:0] r_id [DEPTH];
    logic [AW-1:0]  r_wp;
    logic [AW-1:0]  r_rp;
    logic [CW-1:0]  r_count;
    // storage, pointers and count; reset clears storage so the head reads zero
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_linear[i] <= '0;
                r_id[i]     <= '0;
            end
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_linear[r_wp] <= i_linear;
                r_id[r_wp]     <= i_id;
                r_wp           <= r_wp + AW'(1);
            end
            if (i_pop) r_rp <= r_rp + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end
    assign o_head_linear = r_linear[r_rp];
    assign o_head_id     = r_id[r_rp];
    assign o_count       = r_count;
    assign o_full        = r_count == CW'(DEPTH);
endmodule

// File: rtl/free_tracker.sv
// free_tracker: holds granted allocations until drained, then frees them and closes blocks (optional FREE_TRACKER_USAGE_EN adds a usage counter)
module free_tracker
    import free_tracker_pkg::*;
#(
    parameter  int LBW     = LOCAL_ADDR_BW0,
    parameter  int DEPTH   = FREE_TRACKER_DEPTH,
    parameter  int N_ICFG  = free_tracker_pkg::N_ICFG,
    localparam int ICFG_BW = icfg_bw(N_ICFG),
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               linear_rdy,
    output logic               linear_ack,
    input  logic [LBW-1:0]     i_linear,
    input  logic [ICFG_BW-1:0] i_linear_id,
    input  logic               consume_dval,
    input  logic               blkend_dval,
    output logic               free_dval,
    output logic [ICFG_BW-1:0] o_free_id,
    output logic               blkdone_dval,
    output logic [LBW-1:0]     o_head_linear,
    output logic [ICFG_BW-1:0] o_head_id,
    output logic [CW-1:0]      o_count
`ifdef FREE_TRACKER_USAGE_EN
    ,
    input  logic [LBW:0]       i_sizes [N_ICFG],
    output logic [LBW:0]       o_used
`endif
);
    logic               w_full;
    logic               w_pop;
    logic               w_fire;
    logic               w_pending_nxt;
    logic               r_pending;
    logic               r_free_dval;
    logic [ICFG_BW-1:0] r_free_id;
    logic               r_blkdone_dval;

    free_tracker_fifo #(.LBW(LBW), .IBW(ICFG_BW), .DEPTH(DEPTH)) u_fifo (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_push        (linear_ack),
        .i_pop         (w_pop),
        .i_linear      (i_linear),
        .i_id          (i_linear_id),
        .o_head_linear (o_head_linear),
        .o_head_id     (o_head_id),
        .o_count       (o_count),
        .o_full        (w_full)
    );

    // accept only when room and no block is waiting to close; close once drained
    always_comb begin
        linear_ack    = linear_rdy && !w_full && !r_pending;
        w_pop         = consume_dval && (o_count != '0);
        w_fire        = r_pending && (o_count == '0);
        w_pending_nxt = w_fire ? blkend_dval : (r_pending | blkend_dval);
    end

    // pending-close flag and the one-cycle release pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending      <= 1'b0;
            r_free_dval    <= 1'b0;
            r_free_id      <= '0;
            r_blkdone_dval <= 1'b0;
        end else begin
            r_pending      <= w_pending_nxt;
            r_free_dval    <= w_pop;
            r_free_id      <= w_pop ? o_head_id : r_free_id;
            r_blkdone_dval <= w_fire;
        end
    end

    assign free_dval    = r_free_dval;
    assign o_free_id    = r_free_id;
    assign blkdone_dval = r_blkdone_dval;

`ifdef FREE_TRACKER_USAGE_EN
    logic [LBW:0] w_push_size;
    logic [LBW:0] w_pop_size;
    logic [LBW:0] r_used;
    // size lookups for the pushed id and the head id; unknown ids count as zero
    always_comb begin
        w_push_size = '0;
        w_pop_size  = '0;
        for (int i = 0; i < N_ICFG; i++) begin
            if (i_linear_id == ICFG_BW'(i)) w_push_size = i_sizes[i];
            if (o_head_id == ICFG_BW'(i)) w_pop_size = i_sizes[i];
        end
    end
    // occupied space: grows on accept, shrinks on release, both in one update
    always_ff @(posedge i_clk) begin
        if (i_rst) r_used <= '0;
        else r_used <= r_used + (linear_ack ? w_push_size : '0) - (w_pop ? w_pop_size : '0);
    end
    assign o_used = r_used;
`endif
endmodule
